arty_dma_axi_bridge: RTL and testbench

ARTY_DMA_AXI_BRIDGE -- requirements
Module: arty_dma_axi_bridge

---
 rtl/arty_dma_axi_bridge.sv | 145 ++++++++++++++
 tb/tb_arty_dma_axi_bridge.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arty_dma_axi_bridge.sv
// arty_dma_axi_bridge: round-robin bridge from bsg cache DMA channels onto one AXI4 master port,
// one burst outstanding at a time.
module arty_dma_axi_bridge #(
  parameter int num_ch_p = 2,
  parameter int addr_width_p = 28,
  parameter int data_width_p = 64,
  parameter int burst_len_p = 4,
  parameter int axi_id_width_p = 4,
  parameter int axi_addr_width_p = 28,
  parameter logic [axi_addr_width_p-1:0] base_addr_p = '0
) (
  input  logic                                  clk_i,
  input  logic                                  reset_n_i,
  input  logic [num_ch_p*(addr_width_p+1)-1:0]  dma_pkt_i,
  input  logic [num_ch_p-1:0]                   dma_pkt_v_i,
  output logic [num_ch_p-1:0]                   dma_pkt_yumi_o,
  output logic [data_width_p-1:0]               dma_data_o,
  output logic [num_ch_p-1:0]                   dma_data_v_o,
  input  logic [num_ch_p-1:0]                   dma_data_ready_and_i,
  input  logic [num_ch_p*data_width_p-1:0]      dma_data_i,
  input  logic [num_ch_p-1:0]                   dma_data_v_i,
  output logic [num_ch_p-1:0]                   dma_data_yumi_o,
  output logic [axi_id_width_p-1:0]             axi_awid_o,
  output logic [axi_addr_width_p-1:0]           axi_awaddr_o,
  output logic [7:0]                            axi_awlen_o,
  output logic [2:0]                            axi_awsize_o,
  output logic [1:0]                            axi_awburst_o,
  output logic                                  axi_awvalid_o,
  input  logic                                  axi_awready_i,
  output logic [data_width_p-1:0]               axi_wdata_o,
  output logic [data_width_p/8-1:0]             axi_wstrb_o,
  output logic                                  axi_wlast_o,
  output logic                                  axi_wvalid_o,
  input  logic                                  axi_wready_i,
  input  logic [axi_id_width_p-1:0]             axi_bid_i,
  input  logic [1:0]                            axi_bresp_i,
  input  logic                                  axi_bvalid_i,
  output logic                                  axi_bready_o,
  output logic [axi_id_width_p-1:0]             axi_arid_o,
  output logic [axi_addr_width_p-1:0]           axi_araddr_o,
  output logic [7:0]                            axi_arlen_o,
  output logic [2:0]                            axi_arsize_o,
  output logic [1:0]                            axi_arburst_o,
  output logic                                  axi_arvalid_o,
  input  logic                                  axi_arready_i,
  input  logic [axi_id_width_p-1:0]             axi_rid_i,
  input  logic [data_width_p-1:0]               axi_rdata_i,
  input  logic [1:0]                            axi_rresp_i,
  input  logic                                  axi_rlast_i,
  input  logic                                  axi_rvalid_i,
  output logic                                  axi_rready_o,
  output logic                                  busy_o,
  output logic                                  error_o
);
  localparam int ch_w = num_ch_p > 1 ? $clog2(num_ch_p) : 1;
  localparam int cnt_w = $clog2(burst_len_p + 1);
  localparam int pkt_w = addr_width_p + 1;
  typedef enum logic [2:0] {IDLE, AR, R, AW, W, B} state_e;
  state_e r_state, w_state_n;
  logic [ch_w-1:0] r_rr, r_ch, w_grant, w_k;
  logic [addr_width_p-1:0] r_addr;
  logic [cnt_w-1:0] r_cnt;
  logic r_err, w_found, w_rhs, w_whs, w_last_beat, w_err;
  logic [pkt_w-1:0] w_pkt;
  logic [axi_addr_width_p-1:0] w_axi_addr;
  logic [axi_id_width_p-1:0] w_id;
  // descending scan so the channel closest above rr_ptr is the one left standing
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_k = '0;
    for (int i = num_ch_p - 1; i >= 0; i--) begin
      w_k = ch_w'((int'(r_rr) + i) % num_ch_p);
      if (dma_pkt_v_i[w_k]) begin
        w_found = 1'b1;
        w_grant = w_k;
      end
    end
  end
  assign w_pkt = dma_pkt_i[int'(w_grant)*pkt_w +: pkt_w];
  assign w_axi_addr = base_addr_p + axi_addr_width_p'(r_addr);
  assign w_id = axi_id_width_p'(r_ch);
  assign w_rhs = (r_state == R) && axi_rvalid_i && axi_rready_o;
  assign w_whs = (r_state == W) && axi_wvalid_o && axi_wready_i;
  assign w_last_beat = r_cnt == cnt_w'(burst_len_p - 1);
  // rlast must coincide exactly with the final beat; either mismatch direction is an error
  assign w_err = (w_rhs && (axi_rresp_i != 2'b00 || axi_rid_i != w_id || axi_rlast_i != w_last_beat)) ||
                 ((r_state == B) && axi_bvalid_i && (axi_bresp_i != 2'b00 || axi_bid_i != w_id));
  assign dma_pkt_yumi_o = (r_state == IDLE && w_found) ? num_ch_p'(1) << w_grant : '0;
  assign dma_data_o = axi_rdata_i;
  assign dma_data_v_o = num_ch_p'(r_state == R && axi_rvalid_i) << r_ch;
  assign axi_rready_o = (r_state == R) && dma_data_ready_and_i[r_ch];
  assign axi_wvalid_o = (r_state == W) && dma_data_v_i[r_ch];
  assign axi_wdata_o = dma_data_i[int'(r_ch)*data_width_p +: data_width_p];
  assign dma_data_yumi_o = num_ch_p'(w_whs) << r_ch;
  assign axi_wlast_o = (r_state == W) && w_last_beat;
  assign axi_wstrb_o = '1;
  assign axi_bready_o = r_state == B;
  assign axi_arvalid_o = r_state == AR;
  assign axi_awvalid_o = r_state == AW;
  assign axi_arid_o = w_id;
  assign axi_awid_o = w_id;
  assign axi_araddr_o = w_axi_addr;
  assign axi_awaddr_o = w_axi_addr;
  assign axi_arlen_o = 8'(burst_len_p - 1);
  assign axi_awlen_o = 8'(burst_len_p - 1);
  assign axi_arsize_o = 3'($clog2(data_width_p / 8));
  assign axi_awsize_o = 3'($clog2(data_width_p / 8));
  assign axi_arburst_o = 2'b01;
  assign axi_awburst_o = 2'b01;
  assign busy_o = r_state != IDLE;
  assign error_o = r_err;
  always_comb begin
    w_state_n = r_state;
    case (r_state)
      IDLE:    if (w_found) w_state_n = w_pkt[addr_width_p] ? AW : AR;
      AR:      if (axi_arready_i) w_state_n = R;
      R:       if (w_rhs && axi_rlast_i) w_state_n = IDLE;
      AW:      if (axi_awready_i) w_state_n = W;
      W:       if (w_whs && w_last_beat) w_state_n = B;
      B:       if (axi_bvalid_i) w_state_n = IDLE;
      default: w_state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state <= IDLE;
      r_rr <= '0;
      r_ch <= '0;
      r_addr <= '0;
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_state <= w_state_n;
      if (r_state == IDLE && w_found) begin
        r_rr <= (w_grant == ch_w'(num_ch_p - 1)) ? '0 : w_grant + 1'b1;
        r_ch <= w_grant;
        r_addr <= w_pkt[addr_width_p-1:0];
      end
      if (r_state == AR || r_state == AW) r_cnt <= '0;
      else if (w_rhs || w_whs) r_cnt <= r_cnt + 1'b1;
      if (w_err) r_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_arty_dma_axi_bridge.sv
// tb_arty_dma_axi_bridge: directed stimulus with queued expectations checked by a negedge monitor.
module tb_arty_dma_axi_bridge;
  logic clk = 1'b0, reset_n = 1'b0;
  always #5 clk = ~clk;
  logic [57:0] pkt = '0;
  logic [1:0] pkt_v = '0, pkt_yumi, dma_v, dma_rdy = 2'b11, dv_in = '0, d_yumi;
  logic [63:0] dma_data, wdata, rdata = '0;
  logic [127:0] wdata_in = '0;
  logic [3:0] awid, arid, bid = '0, rid = '0;
  logic [27:0] awaddr, araddr;
  logic [7:0] awlen, arlen, wstrb;
  logic [2:0] awsize, arsize;
  logic [1:0] awburst, arburst, bresp = '0, rresp = '0;
  logic awvalid, awready = 1'b0, wlast, wvalid, wready = 1'b0, bvalid = 1'b0, bready;
  logic arvalid, arready = 1'b0, rlast = 1'b0, rvalid = 1'b0, rready, busy, err;

  arty_dma_axi_bridge dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .dma_pkt_i(pkt), .dma_pkt_v_i(pkt_v), .dma_pkt_yumi_o(pkt_yumi),
    .dma_data_o(dma_data), .dma_data_v_o(dma_v), .dma_data_ready_and_i(dma_rdy),
    .dma_data_i(wdata_in), .dma_data_v_i(dv_in), .dma_data_yumi_o(d_yumi),
    .axi_awid_o(awid), .axi_awaddr_o(awaddr), .axi_awlen_o(awlen), .axi_awsize_o(awsize),
    .axi_awburst_o(awburst), .axi_awvalid_o(awvalid), .axi_awready_i(awready),
    .axi_wdata_o(wdata), .axi_wstrb_o(wstrb), .axi_wlast_o(wlast), .axi_wvalid_o(wvalid),
    .axi_wready_i(wready),
    .axi_bid_i(bid), .axi_bresp_i(bresp), .axi_bvalid_i(bvalid), .axi_bready_o(bready),
    .axi_arid_o(arid), .axi_araddr_o(araddr), .axi_arlen_o(arlen), .axi_arsize_o(arsize),
    .axi_arburst_o(arburst), .axi_arvalid_o(arvalid), .axi_arready_i(arready),
    .axi_rid_i(rid), .axi_rdata_i(rdata), .axi_rresp_i(rresp), .axi_rlast_i(rlast),
    .axi_rvalid_i(rvalid), .axi_rready_o(rready),
    .busy_o(busy), .error_o(err)
  );

  typedef struct packed { logic [27:0] a; logic [3:0] id; } addr_t;
  typedef struct packed { int ch; logic [63:0] d; logic last; } beat_t;
  addr_t exp_ar[$], exp_aw[$], a_m;
  beat_t exp_rd[$], exp_w[$], b_m;
  int exp_g[$], g_m;
  int checks = 0, failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic miss(input string nm);
    checks++;
    failures++;
    $display("FAIL %s: expected event did not happen", nm);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (pkt_yumi != 2'b00) begin
        if (exp_g.size() == 0) miss("grant_unexpected");
        else begin
          g_m = exp_g.pop_front();
          chk("grant", pkt_yumi, 2'b01 << g_m);
        end
      end
      if (arvalid && arready) begin
        if (exp_ar.size() == 0) miss("ar_unexpected");
        else begin
          a_m = exp_ar.pop_front();
          chk("araddr", araddr, a_m.a);
          chk("arid", arid, a_m.id);
          chk("arlen", arlen, 3);
          chk("arsize", arsize, 3);
          chk("arburst", arburst, 1);
        end
      end
      if (awvalid && awready) begin
        if (exp_aw.size() == 0) miss("aw_unexpected");
        else begin
          a_m = exp_aw.pop_front();
          chk("awaddr", awaddr, a_m.a);
          chk("awid", awid, a_m.id);
          chk("awlen", awlen, 3);
          chk("awsize", awsize, 3);
          chk("awburst", awburst, 1);
        end
      end
      if (wvalid && wready) begin
        if (exp_w.size() == 0) miss("w_unexpected");
        else begin
          b_m = exp_w.pop_front();
          chk("wdata", wdata, b_m.d);
          chk("wlast", wlast, b_m.last);
          chk("wstrb", wstrb, 8'hFF);
          chk("wyumi", d_yumi, 2'b01 << b_m.ch);
        end
      end
      for (int c = 0; c < 2; c++) begin
        if (dma_v[c] && dma_rdy[c]) begin
          if (exp_rd.size() == 0) miss("rd_unexpected");
          else begin
            b_m = exp_rd.pop_front();
            chk("rd_ch", c, b_m.ch);
            chk("rd_data", dma_data, b_m.d);
            chk("rd_rready", rready, 1);
          end
        end
      end
    end
  end

  task automatic send_pkt(input int ch, input bit we, input logic [27:0] a);
    int n = 0;
    tick();
    pkt[ch*29 +: 29] = {we, a};
    pkt_v[ch] = 1'b1;
    exp_g.push_back(ch);
    do begin @(negedge clk); n++; end while (!pkt_yumi[ch] && n < 50);
    if (!pkt_yumi[ch]) miss("grant_wait");
    tick();
    pkt_v[ch] = 1'b0;
    chk("addr_valid_latency", we ? awvalid : arvalid, 1);
  endtask

  task automatic ar_phase();
    int n = 0;
    do begin @(negedge clk); n++; end while (!arvalid && n < 50);
    if (!arvalid) miss("arvalid_wait");
    tick();
    arready = 1'b1;
    tick();
    arready = 1'b0;
  endtask

  task automatic aw_phase();
    int n = 0;
    do begin @(negedge clk); n++; end while (!awvalid && n < 50);
    if (!awvalid) miss("awvalid_wait");
    tick();
    awready = 1'b1;
    tick();
    awready = 1'b0;
  endtask

  task automatic r_phase(input int ch, input int nb, input int lastb, input int stall_at, input logic [63:0] base);
    int n;
    for (int b = 0; b < nb; b++) begin
      rvalid = 1'b1;
      rid = 4'(ch);
      rdata = base + 64'(b);
      rlast = (b == lastb);
      exp_rd.push_back('{ch, base + 64'(b), b == lastb});
      if (b == stall_at) begin
        dma_rdy[ch] = 1'b0;
        for (int s = 0; s < 3; s++) begin
          @(negedge clk);
          chk("rready_bp", rready, 0);
          chk("dma_v_bp", dma_v, 2'b01 << ch);
          tick();
        end
        dma_rdy[ch] = 1'b1;
      end
      n = 0;
      do begin @(negedge clk); n++; end while (!rready && n < 50);
      if (!rready) miss("r_wait");
      else chk("dma_v_onehot", dma_v, 2'b01 << ch);
      tick();
    end
    rvalid = 1'b0;
    rlast = 1'b0;
  endtask

  task automatic w_phase(input int ch, input int stall, input logic [63:0] base);
    int n;
    for (int b = 0; b < 4; b++) begin
      dv_in[ch] = 1'b1;
      wdata_in[ch*64 +: 64] = base + 64'(b);
      exp_w.push_back('{ch, base + 64'(b), b == 3});
      wready = 1'b0;
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        chk("wvalid_stall", wvalid, 1);
        chk("wlast_stall", wlast, b == 3);
        tick();
      end
      wready = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!wvalid && n < 50);
      if (!wvalid) miss("w_wait");
      tick();
      wready = 1'b0;
    end
    dv_in[ch] = 1'b0;
  endtask

  task automatic b_phase(input int ch, input logic [1:0] resp);
    int n = 0;
    do begin @(negedge clk); n++; end while (!bready && n < 50);
    if (!bready) miss("bready_wait");
    tick();
    bvalid = 1'b1;
    bid = 4'(ch);
    bresp = resp;
    @(negedge clk);
    chk("bready", bready, 1);
    tick();
    bvalid = 1'b0;
    bresp = 2'b00;
    @(negedge clk);
    chk("b_idle", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_valids", {pkt_yumi, dma_v, d_yumi, arvalid, awvalid, wvalid, bready, rready}, 0);
    tick();
    reset_n = 1'b1;
    // single read, ch0 @0x100
    exp_ar.push_back('{28'h100, 4'd0});
    send_pkt(0, 1'b0, 28'h100);
    ar_phase();
    r_phase(0, 4, 3, -1, 64'hA0A0_0000_0000_0000);
    @(negedge clk);
    chk("read_idle", busy, 0);
    chk("read_err", err, 0);
    // single write, ch1 @0x40, wready stalled 2 cycles per beat
    exp_aw.push_back('{28'h040, 4'd1});
    send_pkt(1, 1'b1, 28'h040);
    aw_phase();
    w_phase(1, 2, 64'hB0B0_0000_0000_0010);
    b_phase(1, 2'b00);
    chk("write_err", err, 0);
    // both channels hold requests: expect 0,1,0,1
    tick();
    pkt = {1'b0, 28'h300, 1'b0, 28'h200};
    pkt_v = 2'b11;
    for (int t = 0; t < 4; t++) begin
      exp_g.push_back(t % 2);
      exp_ar.push_back((t % 2) ? '{28'h300, 4'd1} : '{28'h200, 4'd0});
    end
    for (int t = 0; t < 4; t++) begin
      ar_phase();
      r_phase(t % 2, 4, 3, -1, 64'hC000_0000_0000_0000 + (64'(t) << 16));
    end
    pkt_v = 2'b00;
    // backpressure on ch0 mid-read
    exp_ar.push_back('{28'h140, 4'd0});
    send_pkt(0, 1'b0, 28'h140);
    ar_phase();
    r_phase(0, 4, 3, 1, 64'hD0D0_0000_0000_0000);
    @(negedge clk);
    chk("bp_err", err, 0);
    // rlast arrives on beat 2 of 4
    exp_ar.push_back('{28'h180, 4'd1});
    send_pkt(1, 1'b0, 28'h180);
    ar_phase();
    r_phase(1, 2, 1, -1, 64'hE0E0_0000_0000_0000);
    @(negedge clk);
    chk("early_rlast_err", err, 1);
    chk("early_rlast_idle", busy, 0);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("async_err_clear", err, 0);
    tick();
    reset_n = 1'b1;
    // bresp SLVERR is sticky across a later clean read
    exp_aw.push_back('{28'h1000, 4'd0});
    send_pkt(0, 1'b1, 28'h1000);
    aw_phase();
    w_phase(0, 0, 64'hF0F0_0000_0000_0000);
    b_phase(0, 2'b10);
    chk("bresp_err", err, 1);
    exp_ar.push_back('{28'h1040, 4'd1});
    send_pkt(1, 1'b0, 28'h1040);
    ar_phase();
    r_phase(1, 4, 3, -1, 64'h1234_0000_0000_0000);
    @(negedge clk);
    chk("err_sticky", err, 1);
    // reset during W beat 2 of a ch0 write
    exp_aw.push_back('{28'h080, 4'd0});
    send_pkt(0, 1'b1, 28'h080);
    aw_phase();
    dv_in[0] = 1'b1;
    wdata_in[63:0] = 64'h5555_0000_0000_0000;
    exp_w.push_back('{0, 64'h5555_0000_0000_0000, 1'b0});
    wready = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!wvalid && n < 50);
    if (!wvalid) miss("w_wait_rst");
    tick();
    wready = 1'b0;
    wdata_in[63:0] = 64'h5555_0000_0000_0001;
    @(negedge clk);
    chk("w_beat2_valid", wvalid, 1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("rst_mid_valids", {pkt_yumi, dma_v, d_yumi, arvalid, awvalid, wvalid, bready, rready}, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_err", err, 0);
    dv_in = 2'b00;
    tick();
    reset_n = 1'b1;
    // rr_ptr back at 0: ch0 wins even though ch1 also requests
    tick();
    pkt = {1'b0, 28'h1C0, 1'b0, 28'h180};
    pkt_v = 2'b11;
    exp_g.push_back(0);
    exp_ar.push_back('{28'h180, 4'd0});
    n = 0;
    do begin @(negedge clk); n++; end while (!pkt_yumi[0] && n < 50);
    if (!pkt_yumi[0]) miss("grant_after_reset");
    tick();
    pkt_v = 2'b00;
    ar_phase();
    r_phase(0, 4, 3, -1, 64'h7777_0000_0000_0000);
    @(negedge clk);
    chk("final_idle", busy, 0);
    chk("final_err", err, 0);
    chk("q_grant_empty", exp_g.size(), 0);
    chk("q_ar_empty", exp_ar.size(), 0);
    chk("q_aw_empty", exp_aw.size(), 0);
    chk("q_w_empty", exp_w.size(), 0);
    chk("q_rd_empty", exp_rd.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
